ext_in_port: RTL

//  Input-side peer of the OUT port. Accepts bytes from an external producer over a

---
 rtl/cpu_defs_pkg.sv | 16 +
 rtl/ext_in_port_if.sv | 12 +
 rtl/sync_fifo.sv | 51 +++++
 rtl/ext_in_port.sv | 103 ++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: opcodes, datapath width and the IN-port controller states.
package cpu_defs_pkg;

  localparam int unsigned DATA_W = 8;
  localparam logic [3:0]  OP_OUT = 4'h6;
  localparam logic [3:0]  OP_IN  = 4'h7;

  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_REL  = 2'd2
  } in_state_e;

endpackage

// File: rtl/ext_in_port_if.sv
// Producer-side valid/ready byte channel into the IN port.
interface ext_in_port_if;
  import cpu_defs_pkg::*;

  data_t ext_data;
  logic  ext_valid;
  logic  ext_ready;

  modport master (output ext_data, output ext_valid, input ext_ready);
  modport slave  (input ext_data, input ext_valid, output ext_ready);

endinterface

// File: rtl/sync_fifo.sv
// Small circular FIFO updated on the falling clock edge; push when full and pop when
// empty are ignored, so level never leaves 0..DEPTH.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [WIDTH-1:0]             head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

  // Storage needs no reset: the head is only used while level != 0.
  always_ff @(negedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ext_in_port.sv
// IN port: buffers producer bytes and serves the IN instruction in EXE, stalling the PC
// while the buffer is empty; a watchdog releases an IN stuck waiting for too long.
module ext_in_port
  import cpu_defs_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  ext_in_port_if.slave                 ext,
  input  logic [3:0]                   op,
  output logic [DATA_W-1:0]            in_data,
  output logic                         pc_en,
  output logic                         in_ack,
  output logic                         in_timeout,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int unsigned WDOG_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT+1);

  in_state_e         state;
  in_state_e         state_nx;
  logic [WDOG_W-1:0] wdog;
  logic [WDOG_W-1:0] wdog_nx;
  logic              in_ack_nx;
  logic              in_timeout_nx;

  logic              is_in;
  logic              rel;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  data_t             head;

  assign is_in         = (op == OP_IN);
  assign rel           = (state == ST_REL);
  assign ext.ext_ready = ~fifo_full;
  assign push          = ext.ext_valid & ~fifo_full;
  assign pop           = is_in & ~fifo_empty & ~rel;
  assign in_data       = (fifo_empty | rel) ? '0 : head;
  assign pc_en         = ~(is_in & fifo_empty & ~rel);

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (ext.ext_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level),
    .head  (head)
  );

  // Watchdog compares against the count before increment, so it fires TIMEOUT cycles after entry.
  always_comb begin
    state_nx      = state;
    wdog_nx       = wdog;
    in_ack_nx     = pop | rel;
    in_timeout_nx = in_timeout;
    case (state)
      ST_RUN: begin
        if (is_in & fifo_empty) begin
          state_nx = ST_WAIT;
          wdog_nx  = WDOG_W'(1);
        end
      end
      ST_WAIT: begin
        wdog_nx = wdog + WDOG_W'(1);
        if (pop) begin
          state_nx = ST_RUN;
        end else if ((TIMEOUT != 0) && (wdog == WDOG_W'(TIMEOUT))) begin
          state_nx      = ST_REL;
          in_timeout_nx = 1'b1;
        end else if (!is_in) begin
          state_nx = ST_RUN;
        end
      end
      ST_REL:  state_nx = ST_RUN;
      default: state_nx = ST_RUN;
    endcase
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_RUN;
      wdog       <= '0;
      in_ack     <= 1'b0;
      in_timeout <= 1'b0;
    end else begin
      state      <= state_nx;
      wdog       <= wdog_nx;
      in_ack     <= in_ack_nx;
      in_timeout <= in_timeout_nx;
    end
  end

endmodule
